neuron_mac: RTL and testbench

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/neuron_pkg.sv | 21 ++
 rtl/mac_lane.sv | 107 ++++++++++
 rtl/neuron_mac.sv | 110 +++++++++++
 tb/tb_neuron_mac.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron MAC block: the frame FSM state
// encoding and signed saturation limits for an arbitrary word width.
package neuron_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    BIAS  = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Largest signed value representable in 'width' bits, returned 64 bits wide.
  function automatic logic signed [63:0] satMax(input int width);
    satMax = (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Smallest signed value representable in 'width' bits, returned 64 bits wide.
  function automatic logic signed [63:0] satMin(input int width);
    satMin = -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One neuron lane: signed multiply, saturating accumulate, bias add, and
// output rescale with saturation and optional ReLU. The lane result is
// combinational from the accumulator so it stays frozen while the
// accumulator is idle during back-pressure.
module mac_lane
  import neuron_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int INT_BITS  = 4,
  parameter int RELU      = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clear,
  input  logic                        i_accum,
  input  logic                        i_latchBias,
  input  logic                        i_addBias,
  input  logic signed [WORD_SIZE-1:0] i_data,
  input  logic signed [WORD_SIZE-1:0] i_weight,
  input  logic signed [WORD_SIZE-1:0] i_bias,
  output logic signed [WORD_SIZE-1:0] o_result
);

  localparam int FRAC_BITS = WORD_SIZE - INT_BITS;
  localparam int ACC_W     = 2 * WORD_SIZE;
  localparam int SH_W      = ACC_W - FRAC_BITS;

  localparam logic signed [63:0] ACC_MAX64 = satMax(ACC_W);
  localparam logic signed [63:0] ACC_MIN64 = satMin(ACC_W);
  localparam logic signed [63:0] OUT_MAX64 = satMax(WORD_SIZE);
  localparam logic signed [63:0] OUT_MIN64 = satMin(WORD_SIZE);

  localparam logic signed [ACC_W-1:0]     ACC_MAX = ACC_MAX64[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0]     ACC_MIN = ACC_MIN64[ACC_W-1:0];
  localparam logic signed [WORD_SIZE-1:0] OUT_MAX = OUT_MAX64[WORD_SIZE-1:0];
  localparam logic signed [WORD_SIZE-1:0] OUT_MIN = OUT_MIN64[WORD_SIZE-1:0];

  logic signed [ACC_W-1:0]     r_acc;
  logic signed [WORD_SIZE-1:0] r_bias;

  logic signed [ACC_W-1:0]     w_dataExt;
  logic signed [ACC_W-1:0]     w_weightExt;
  logic signed [ACC_W-1:0]     w_product;
  logic signed [ACC_W-1:0]     w_biasShift;
  logic signed [SH_W-1:0]      w_shifted;
  logic signed [63:0]          w_wide;
  logic signed [WORD_SIZE-1:0] w_sat;

  // Add two accumulator-width values, clamping to the rails when the
  // extra carry bit disagrees with the sign bit (signed overflow).
  function automatic logic signed [ACC_W-1:0] satAdd(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      satAdd = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      satAdd = sum[ACC_W-1:0];
    end
  endfunction

  assign w_dataExt   = {{WORD_SIZE{i_data[WORD_SIZE-1]}}, i_data};
  assign w_weightExt = {{WORD_SIZE{i_weight[WORD_SIZE-1]}}, i_weight};
  assign w_product   = w_dataExt * w_weightExt;
  assign w_biasShift = {{INT_BITS{r_bias[WORD_SIZE-1]}}, r_bias, {FRAC_BITS{1'b0}}};
  assign w_shifted   = r_acc[ACC_W-1:FRAC_BITS];

  // Accumulator and latched bias; clearing on output handoff wins over
  // everything, otherwise accumulate a product or the scaled bias.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc  <= '0;
      r_bias <= '0;
    end else begin
      if (i_clear) begin
        r_acc <= '0;
      end else if (i_accum) begin
        r_acc <= satAdd(r_acc, w_product);
      end else if (i_addBias) begin
        r_acc <= satAdd(r_acc, w_biasShift);
      end
      if (i_latchBias) begin
        r_bias <= i_bias;
      end
    end
  end

  // Drop the fraction bits, clamp to the output word range, then apply ReLU.
  always_comb begin
    w_wide = {{(64-SH_W){w_shifted[SH_W-1]}}, w_shifted};
    if (w_wide > OUT_MAX64) begin
      w_sat = OUT_MAX;
    end else if (w_wide < OUT_MIN64) begin
      w_sat = OUT_MIN;
    end else begin
      w_sat = w_shifted[WORD_SIZE-1:0];
    end
    if ((RELU != 0) && w_sat[WORD_SIZE-1]) begin
      o_result = '0;
    end else begin
      o_result = w_sat;
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Multi-lane neuron MAC: accumulates N_INPUTS products of a shared sample
// against per-lane weights, adds a per-lane bias, and presents the rescaled
// lane results with a valid/ready handshake.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int INT_BITS  = 4,
  parameter int N_CH      = 4,
  parameter int N_INPUTS  = 8,
  parameter int RELU      = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [WORD_SIZE-1:0]      data_i,
  input  logic [N_CH*WORD_SIZE-1:0] weight_i,
  input  logic [N_CH*WORD_SIZE-1:0] bias_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [N_CH*WORD_SIZE-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N_INPUTS - 1);

  state_t r_state;
  state_t w_nextState;

  logic [CNT_W-1:0]          r_count;
  logic                      w_transfer;
  logic                      w_lastInput;
  logic                      w_accept;
  logic [N_CH*WORD_SIZE-1:0] w_results;

  assign w_transfer  = valid_i && ready_o;
  assign w_lastInput = (r_count == LAST_COUNT);
  assign w_accept    = valid_o && ready_i;
  assign data_o      = valid_o ? w_results : '0;

  // Frame state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs: inputs only in ACCUM, results only in OUT.
  always_comb begin
    w_nextState = r_state;
    ready_o     = 1'b0;
    valid_o     = 1'b0;
    case (r_state)
      ACCUM: begin
        ready_o = 1'b1;
        if (w_transfer && w_lastInput) begin
          w_nextState = BIAS;
        end
      end
      BIAS: begin
        w_nextState = OUT;
      end
      OUT: begin
        valid_o = 1'b1;
        if (ready_i) begin
          w_nextState = ACCUM;
        end
      end
      default: begin
        w_nextState = ACCUM;
      end
    endcase
  end

  // Input counter: wraps to zero on the transfer that closes a frame.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (w_transfer) begin
      r_count <= w_lastInput ? '0 : r_count + 1'b1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    logic [WORD_SIZE-1:0] w_laneOut;

    mac_lane #(
      .WORD_SIZE(WORD_SIZE),
      .INT_BITS (INT_BITS),
      .RELU     (RELU)
    ) u_lane (
      .i_clk      (clk_i),
      .i_reset    (reset_i),
      .i_clear    (w_accept),
      .i_accum    (w_transfer),
      .i_latchBias(w_transfer && w_lastInput),
      .i_addBias  (r_state == BIAS),
      .i_data     (data_i),
      .i_weight   (weight_i[k*WORD_SIZE +: WORD_SIZE]),
      .i_bias     (bias_i[k*WORD_SIZE +: WORD_SIZE]),
      .o_result   (w_laneOut)
    );

    assign w_results[k*WORD_SIZE +: WORD_SIZE] = w_laneOut;
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: two instances (ReLU on and off) share one stimulus
// stream. The driver pushes the reference result of every frame into a
// scoreboard queue; an independent monitor compares whenever valid_o is up.
module tb_neuron_mac;

  localparam int W   = 16;
  localparam int IB  = 4;
  localparam int FB  = W - IB;
  localparam int NCH = 2;
  localparam int NIN = 4;

  localparam longint ACC_MAX = (longint'(1) <<< 31) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< 31);

  logic               clk_i = 1'b0;
  logic               reset_i;
  logic [W-1:0]       data_i;
  logic [NCH*W-1:0]   weight_i;
  logic [NCH*W-1:0]   bias_i;
  logic               valid_i;
  logic               ready_i;

  logic               readyRelu, validRelu, readyLin, validLin;
  logic [NCH*W-1:0]   dataRelu, dataLin;

  always #5 clk_i = ~clk_i;

  neuron_mac #(.WORD_SIZE(W), .INT_BITS(IB), .N_CH(NCH), .N_INPUTS(NIN), .RELU(1)) dutRelu (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (data_i),
    .weight_i(weight_i),
    .bias_i  (bias_i),
    .valid_i (valid_i),
    .ready_o (readyRelu),
    .data_o  (dataRelu),
    .valid_o (validRelu),
    .ready_i (ready_i)
  );

  neuron_mac #(.WORD_SIZE(W), .INT_BITS(IB), .N_CH(NCH), .N_INPUTS(NIN), .RELU(0)) dutLin (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (data_i),
    .weight_i(weight_i),
    .bias_i  (bias_i),
    .valid_i (valid_i),
    .ready_o (readyLin),
    .data_o  (dataLin),
    .valid_o (validLin),
    .ready_i (ready_i)
  );

  typedef struct {
    logic [NCH*W-1:0] expRelu;
    logic [NCH*W-1:0] expLin;
    int               lastCycle;
  } expect_t;

  expect_t          sbQueue[$];
  int               checks     = 0;
  int               errors     = 0;
  int               cycle      = 0;
  int               framesDone = 0;
  longint           modelAcc[NCH];
  logic [W-1:0]     frameData[NIN];
  logic [NCH*W-1:0] frameWeight[NIN];
  logic [NCH*W-1:0] frameBias;

  // Free-running cycle index used to measure result latency.
  always @(posedge clk_i) cycle <= cycle + 1;

  // Single comparison point: counts every check and reports any miss.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, actual, required, cycle);
    end
  endtask

  // Clamp a running sum to the signed 32-bit accumulator range.
  function automatic longint satAcc(input longint x);
    if (x > ACC_MAX) return ACC_MAX;
    if (x < ACC_MIN) return ACC_MIN;
    return x;
  endfunction

  // Scale the accumulator back to a word, clamp, and optionally apply ReLU.
  function automatic logic [W-1:0] modelOut(input longint acc, input bit relu);
    longint v;
    v = acc >>> FB;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    if (relu && v < 0) v = 0;
    return v[W-1:0];
  endfunction

  // Fill the frame tables with one sample value and fixed per-lane weights.
  task automatic setFrame(input logic [W-1:0] d, input logic [W-1:0] w0, input logic [W-1:0] w1,
                          input logic [W-1:0] b0, input logic [W-1:0] b1);
    for (int i = 0; i < NIN; i++) begin
      frameData[i]   = d;
      frameWeight[i] = {w1, w0};
    end
    frameBias = {b1, b0};
  endtask

  // Drive one full frame, optionally with idle gaps between transfers and
  // back-pressure on the result, then wait for the monitor to see it accepted.
  task automatic applyStimulus(input int gapMode, input int stallCycles);
    int      target;
    int      budget;
    int      stalled;
    expect_t e;
    target  = framesDone + 1;
    budget  = 0;
    stalled = 0;
    for (int k = 0; k < NCH; k++) modelAcc[k] = 0;
    for (int i = 0; i < NIN; i++) begin
      int gaps;
      gaps = (gapMode == 1 && i > 0) ? 1 : ((gapMode == 2) ? int'($urandom_range(0, 2)) : 0);
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk_i);
        valid_i  = 1'b0;
        data_i   = W'($urandom);
        weight_i = $urandom;
        bias_i   = $urandom;
        checkOutput("readyIdle", {readyRelu, readyLin}, 2'b11);
      end
      @(negedge clk_i);
      valid_i  = 1'b1;
      data_i   = frameData[i];
      weight_i = frameWeight[i];
      bias_i   = (i == NIN - 1) ? frameBias : $urandom;
      checkOutput("readyAccum", {readyRelu, readyLin}, 2'b11);
      for (int k = 0; k < NCH; k++) begin
        modelAcc[k] = satAcc(modelAcc[k] +
                      longint'($signed(frameData[i])) * longint'($signed(frameWeight[i][k*W +: W])));
      end
    end
    for (int k = 0; k < NCH; k++) begin
      modelAcc[k] = satAcc(modelAcc[k] + (longint'($signed(frameBias[k*W +: W])) <<< FB));
      e.expRelu[k*W +: W] = modelOut(modelAcc[k], 1'b1);
      e.expLin[k*W +: W]  = modelOut(modelAcc[k], 1'b0);
    end
    e.lastCycle = cycle;
    sbQueue.push_back(e);
    if (stallCycles > 0) ready_i = 1'b0;
    while (1) begin
      @(negedge clk_i);
      if (framesDone == target) begin
        valid_i = 1'b0;
        break;
      end
      if (budget >= 40) begin
        checkOutput("frameTimeout", 64'(framesDone), 64'(target));
        valid_i = 1'b0;
        ready_i = 1'b1;
        break;
      end
      budget++;
      valid_i  = 1'($urandom_range(0, 1));
      data_i   = W'($urandom);
      weight_i = $urandom;
      bias_i   = $urandom;
      if (validRelu) stalled++;
      ready_i = (stallCycles == 0) || (stalled > stallCycles);
    end
  endtask

  // Monitor: compares every valid cycle against the scoreboard head and
  // pops it on the handshake; with valid low both outputs must read zero.
  initial begin
    logic prevValid;
    prevValid = 1'b0;
    forever begin
      @(negedge clk_i);
      #1;
      if (reset_i) begin
        prevValid = 1'b0;
      end else begin
        if (validRelu) begin
          checkOutput("queueNonEmpty", 64'(sbQueue.size() != 0), 64'd1);
          if (sbQueue.size() != 0) begin
            if (!prevValid) checkOutput("latency", 64'(cycle - sbQueue[0].lastCycle), 64'd2);
            checkOutput("validLin", 64'(validLin), 64'd1);
            checkOutput("readyOut", {readyRelu, readyLin}, 2'b00);
            checkOutput("dataRelu", dataRelu, sbQueue[0].expRelu);
            checkOutput("dataLin", dataLin, sbQueue[0].expLin);
            if (ready_i) begin
              void'(sbQueue.pop_front());
              framesDone++;
            end
          end
        end else begin
          checkOutput("idleValidLin", 64'(validLin), 64'd0);
          checkOutput("idleDataRelu", dataRelu, 64'd0);
          checkOutput("idleDataLin", dataLin, 64'd0);
        end
        prevValid = validRelu;
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios first, then randomized frames.
  initial begin
    reset_i  = 1'b1;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    data_i   = '0;
    weight_i = '0;
    bias_i   = '0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    checkOutput("resetValid", {validRelu, validLin}, 2'b00);
    checkOutput("resetData", {dataRelu, dataLin}, 64'd0);
    checkOutput("resetReady", {readyRelu, readyLin}, 2'b11);

    // Basic frame with bias.
    setFrame(16'h1000, 16'h0800, 16'h0800, 16'h1000, 16'h0000);
    applyStimulus(0, 0);

    // Saturation at both rails.
    setFrame(16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000);
    applyStimulus(0, 0);

    // Negative result: ReLU clamps, linear keeps it.
    setFrame(16'h1000, 16'hF000, 16'hF000, 16'h0000, 16'h0000);
    applyStimulus(0, 0);

    // Back-pressure for five cycles, then a normal frame straight after.
    setFrame(16'h1000, 16'h0800, 16'h0800, 16'h1000, 16'h0000);
    applyStimulus(0, 5);
    applyStimulus(0, 0);

    // valid_i toggling every other cycle.
    applyStimulus(1, 0);

    // Reset after two transfers, with a transfer offered on the reset edge.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      valid_i  = 1'b1;
      data_i   = 16'h7FFF;
      weight_i = 32'h7FFF_7FFF;
    end
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    valid_i = 1'b0;
    checkOutput("midResetValid", {validRelu, validLin}, 2'b00);
    checkOutput("midResetData", {dataRelu, dataLin}, 64'd0);
    checkOutput("midResetReady", {readyRelu, readyLin}, 2'b11);
    applyStimulus(0, 0);

    // Randomized frames with random gaps and back-pressure.
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < NIN; i++) begin
        frameData[i]   = W'($urandom);
        frameWeight[i] = $urandom;
      end
      frameBias = $urandom;
      applyStimulus(2, int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk_i);
    checkOutput("queueDrained", 64'(sbQueue.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
